// File: rtl/ternary_dot_stream.sv
// Streaming ternary similarity engine: signed dot product or nonzero-overlap
// count over NUM_WORDS packed trit words, with a one-stage word-sum pipeline.
module ternary_dot_stream #(
    parameter int unsigned TPW       = 16,
    parameter int unsigned NUM_WORDS = 64,
    parameter int unsigned ACC_W     = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic                    mode,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [2*TPW-1:0]        a_word,
    input  logic [2*TPW-1:0]        b_word,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic signed [ACC_W-1:0] result,
    output logic                    err,
    output logic                    busy
);

    localparam int unsigned WS_W  = $clog2(TPW) + 2;
    localparam int unsigned CNT_W = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DRAIN,
        S_DONE
    } state_e;

    state_e                  state_q;
    logic                    mode_q;
    logic [CNT_W-1:0]        cnt_q;
    logic signed [ACC_W-1:0] acc_q;
    logic signed [WS_W-1:0]  pipe_q;
    logic                    pvalid_q;
    logic                    err_sticky_q;
    logic                    in_ready_q;
    logic                    out_valid_q;
    logic signed [ACC_W-1:0] result_q;
    logic                    err_q;
    logic                    busy_q;

    logic signed [WS_W-1:0]  pipe_d;
    logic                    bad_d;
    logic [1:0]              ta;
    logic [1:0]              tb;
    logic signed [ACC_W-1:0] pipe_add;

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign result    = result_q;
    assign err       = err_q;
    assign busy      = busy_q;

    // Sign-extended pipe contribution, zero when the pipe holds no beat.
    assign pipe_add = pvalid_q ? {{(ACC_W-WS_W){pipe_q[WS_W-1]}}, pipe_q} : '0;

    // Word sum of per-trit contributions under the latched mode; flags reserved codes.
    always_comb begin
        pipe_d = '0;
        bad_d  = 1'b0;
        ta     = 2'b01;
        tb     = 2'b01;
        for (int i = 0; i < int'(TPW); i++) begin
            ta = a_word[2*i +: 2];
            tb = b_word[2*i +: 2];
            if (ta == 2'b11 || tb == 2'b11) begin
                bad_d = 1'b1;
            end else if (ta != 2'b01 && tb != 2'b01) begin
                if (mode_q || ta == tb) begin
                    pipe_d = pipe_d + WS_W'(1);
                end else begin
                    pipe_d = pipe_d - WS_W'(1);
                end
            end
        end
    end

    // Control FSM, beat counter, accumulator and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_IDLE;
            mode_q       <= 1'b0;
            cnt_q        <= '0;
            acc_q        <= '0;
            pipe_q       <= '0;
            pvalid_q     <= 1'b0;
            err_sticky_q <= 1'b0;
            in_ready_q   <= 1'b0;
            out_valid_q  <= 1'b0;
            result_q     <= '0;
            err_q        <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            pvalid_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        state_q      <= S_RUN;
                        mode_q       <= mode;
                        cnt_q        <= '0;
                        acc_q        <= '0;
                        err_sticky_q <= 1'b0;
                        err_q        <= 1'b0;
                        in_ready_q   <= 1'b1;
                        busy_q       <= 1'b1;
                    end
                end
                S_RUN: begin
                    acc_q <= acc_q + pipe_add;
                    if (in_valid && in_ready_q) begin
                        pipe_q   <= pipe_d;
                        pvalid_q <= 1'b1;
                        cnt_q    <= cnt_q + CNT_W'(1);
                        if (bad_d) begin
                            err_sticky_q <= 1'b1;
                        end
                        if (cnt_q == CNT_W'(NUM_WORDS - 1)) begin
                            state_q    <= S_DRAIN;
                            in_ready_q <= 1'b0;
                        end
                    end
                end
                S_DRAIN: begin
                    result_q    <= acc_q + pipe_add;
                    err_q       <= err_sticky_q;
                    out_valid_q <= 1'b1;
                    state_q     <= S_DONE;
                end
                S_DONE: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        busy_q      <= 1'b0;
                        state_q     <= S_IDLE;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

endmodule
